uart_lite_responder: RTL and testbench

//   AXI4-Lite slave presenting a UART-Lite register map to a byte-oriented AXI master.

---
 rtl/uart_lite_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_lite_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lite_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_lite_responder: AXI4-Lite UART-Lite register map over 8-bit RX/TX FIFOs
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_lite_responder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] uart_araddr,
  input  logic        uart_arvalid,
  output logic        uart_arready,
  output logic [31:0] uart_rdata,
  output logic [1:0]  uart_rresp,
  output logic        uart_rvalid,
  input  logic        uart_rready,
  input  logic [31:0] uart_awaddr,
  input  logic        uart_awvalid,
  output logic        uart_awready,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  input  logic        uart_wvalid,
  output logic        uart_wready,
  output logic [1:0]  uart_bresp,
  output logic        uart_bvalid,
  input  logic        uart_bready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int                  DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;
  localparam logic [DEPTH_LOG2:0] PTR_ONE     = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_e;

  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];

  logic [DEPTH_LOG2:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [DEPTH_LOG2:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic                overrun_q, overrun_d;

  rd_state_e   rd_state_q, rd_state_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic       aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0] awreg_q, awreg_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic       wstrb0_q, wstrb0_d;
  logic       awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_pop, rx_push, tx_pop, tx_push, stat_rd, flush_tx, flush_rx, do_write;
  logic unused_bits;

  assign unused_bits = ^{uart_araddr[31:4], uart_araddr[1:0], uart_awaddr[31:4],
                         uart_awaddr[1:0], uart_wdata[31:8], uart_wstrb[3:1]};

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[DEPTH_LOG2] != rx_rp_q[DEPTH_LOG2]) &&
                    (rx_wp_q[DEPTH_LOG2-1:0] == rx_rp_q[DEPTH_LOG2-1:0]);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[DEPTH_LOG2] != tx_rp_q[DEPTH_LOG2]) &&
                    (tx_wp_q[DEPTH_LOG2-1:0] == tx_rp_q[DEPTH_LOG2-1:0]);

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rx_pop     = 1'b0;
    stat_rd    = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (uart_arvalid && arready_q) begin
          rd_state_d = R_RESP;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = RESP_OKAY;
          rdata_d    = 32'h0;
          case (uart_araddr[3:2])
            2'd0: begin
              if (rx_empty) begin
                rresp_d = RESP_SLVERR;
              end else begin
                rdata_d = {24'h0, rx_mem[rx_rp_q[DEPTH_LOG2-1:0]]};
                rx_pop  = 1'b1;
              end
            end
            2'd2: begin
              rdata_d = {26'h0, overrun_q, 1'b0, tx_full, tx_empty, rx_full, !rx_empty};
              stat_rd = 1'b1;
            end
            default: ;
          endcase
        end
      end
      R_RESP: begin
        if (uart_rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // AW and W are captured independently; the register access runs once both are held.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awreg_d   = awreg_q;
    wbyte_d   = wbyte_q;
    wstrb0_d  = wstrb0_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    tx_push   = 1'b0;
    flush_tx  = 1'b0;
    flush_rx  = 1'b0;
    do_write  = aw_held_q && w_held_q && !bvalid_q;
    if (uart_awvalid && awready_q) begin
      aw_held_d = 1'b1;
      awreg_d   = uart_awaddr[3:2];
    end
    if (uart_wvalid && wready_q) begin
      w_held_d = 1'b1;
      wbyte_d  = uart_wdata[7:0];
      wstrb0_d = uart_wstrb[0];
    end
    if (do_write) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (awreg_q)
        2'd1: begin
          if (wstrb0_q) begin
            if (tx_full) bresp_d = RESP_SLVERR;
            else         tx_push = 1'b1;
          end
        end
        2'd3: begin
          flush_tx = wbyte_q[0];
          flush_rx = wbyte_q[1];
        end
        default: ;
      endcase
    end else if (bvalid_q && uart_bready) begin
      bvalid_d = 1'b0;
    end
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  // Full/empty come from the registered pointers, so a same-cycle pop or push
  // never changes the outcome of the access decided above.
  always_comb begin
    tx_pop  = !tx_empty && tx_ready;
    rx_push = rx_valid && !rx_full && !flush_rx;
    tx_wp_d = tx_push ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d = tx_pop  ? tx_rp_q + PTR_ONE : tx_rp_q;
    rx_wp_d = rx_push ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d = rx_pop  ? rx_rp_q + PTR_ONE : rx_rp_q;
    if (flush_tx) tx_rp_d = tx_wp_q;
    if (flush_rx) rx_rp_d = rx_wp_q;
    overrun_d = overrun_q;
    if (stat_rd)             overrun_d = 1'b0;
    if (rx_valid && rx_full) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[DEPTH_LOG2-1:0]] <= wbyte_q;
    if (rx_push) rx_mem[rx_wp_q[DEPTH_LOG2-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      overrun_q  <= 1'b0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awreg_q    <= 2'b00;
      wbyte_q    <= 8'h0;
      wstrb0_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      overrun_q  <= overrun_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awreg_q    <= awreg_d;
      wbyte_q    <= wbyte_d;
      wstrb0_q   <= wstrb0_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  assign uart_arready = arready_q;
  assign uart_rvalid  = rvalid_q;
  assign uart_rdata   = rdata_q;
  assign uart_rresp   = rresp_q;
  assign uart_awready = awready_q;
  assign uart_wready  = wready_q;
  assign uart_bvalid  = bvalid_q;
  assign uart_bresp   = bresp_q;
  assign tx_valid     = !tx_empty;
  assign tx_data      = tx_empty ? 8'h0 : tx_mem[tx_rp_q[DEPTH_LOG2-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_uart_lite_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_lite_responder: random traffic checked against a queue-based model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_lite_responder;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] uart_araddr = '0;
  logic        uart_arvalid = 1'b0;
  logic        uart_arready;
  logic [31:0] uart_rdata;
  logic [1:0]  uart_rresp;
  logic        uart_rvalid;
  logic        uart_rready = 1'b0;
  logic [31:0] uart_awaddr = '0;
  logic        uart_awvalid = 1'b0;
  logic        uart_awready;
  logic [31:0] uart_wdata = '0;
  logic [3:0]  uart_wstrb = '0;
  logic        uart_wvalid = 1'b0;
  logic        uart_wready;
  logic [1:0]  uart_bresp;
  logic        uart_bvalid;
  logic        uart_bready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int errs = 0;
  int checks = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       ovr = 1'b0;

  uart_lite_responder #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rstn(rstn),
    .uart_araddr(uart_araddr), .uart_arvalid(uart_arvalid), .uart_arready(uart_arready),
    .uart_rdata(uart_rdata), .uart_rresp(uart_rresp), .uart_rvalid(uart_rvalid),
    .uart_rready(uart_rready),
    .uart_awaddr(uart_awaddr), .uart_awvalid(uart_awvalid), .uart_awready(uart_awready),
    .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb), .uart_wvalid(uart_wvalid),
    .uart_wready(uart_wready), .uart_bresp(uart_bresp), .uart_bvalid(uart_bvalid),
    .uart_bready(uart_bready),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    return {26'h0, ovr, 1'b0, txq.size() == 16, txq.size() == 0,
            rxq.size() == 16, rxq.size() != 0};
  endfunction

  function automatic logic [31:0] rand_addr(input logic [1:0] reg_sel);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = reg_sel;
    return a;
  endfunction

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    @(negedge clk);
    uart_araddr = a;
    uart_arvalid = 1'b1;
    while (!uart_arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("arready_timeout", 32'(uart_arready), 32'd1);
    @(negedge clk);
    uart_arvalid = 1'b0;
    n = 0;
    while (!uart_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("r_latency", n, 0);
    d = uart_rdata;
    r = uart_rresp;
    uart_rready = 1'b1;
    @(negedge clk);
    uart_rready = 1'b0;
    chk("rvalid_drop", 32'(uart_rvalid), 32'd0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] br);
    int  n;
    logic aw_go, w_go;
    n = 0;
    @(negedge clk);
    uart_awaddr = a; uart_awvalid = 1'b1;
    uart_wdata = d;  uart_wstrb = s; uart_wvalid = 1'b1;
    while ((uart_awvalid || uart_wvalid) && n < 20) begin
      aw_go = uart_awvalid && uart_awready;
      w_go  = uart_wvalid && uart_wready;
      @(negedge clk);
      if (aw_go) uart_awvalid = 1'b0;
      if (w_go)  uart_wvalid = 1'b0;
      n++;
    end
    if (n >= 20) chk("aw_w_timeout", {uart_awvalid, uart_wvalid}, 0);
    uart_awvalid = 1'b0; uart_wvalid = 1'b0;
    n = 0;
    while (!uart_bvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("bvalid_timeout", 32'(uart_bvalid), 32'd1);
    br = uart_bresp;
    uart_bready = 1'b1;
    @(negedge clk);
    uart_bready = 1'b0;
    chk("b_handshake", {uart_bvalid, uart_awready, uart_wready}, 3'b011);
  endtask

  task automatic m_write(input logic [1:0] reg_sel, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] br, exp_br;
    exp_br = 2'b00;
    if (reg_sel == 2'd1 && s[0]) begin
      if (txq.size() == 16) exp_br = 2'b10;
      else txq.push_back(d[7:0]);
    end
    if (reg_sel == 2'd3) begin
      if (d[0]) txq.delete();
      if (d[1]) rxq.delete();
    end
    axi_write(rand_addr(reg_sel), d, s, br);
    chk("bresp", br, exp_br);
  endtask

  task automatic m_read(input logic [1:0] reg_sel);
    logic [31:0] d, exp_d;
    logic [1:0]  r, exp_r;
    exp_d = 32'h0;
    exp_r = 2'b00;
    if (reg_sel == 2'd0) begin
      if (rxq.size() == 0) exp_r = 2'b10;
      else exp_d = {24'h0, rxq.pop_front()};
    end else if (reg_sel == 2'd2) begin
      exp_d = stat_exp();
      ovr = 1'b0;
    end
    axi_read(rand_addr(reg_sel), d, r);
    chk(reg_sel == 2'd2 ? "stat_rdata" : "rdata", d, exp_d);
    chk("rresp", r, exp_r);
  endtask

  task automatic m_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    if (rxq.size() == 16) ovr = 1'b1;
    else rxq.push_back(b);
  endtask

  task automatic m_tx_pop();
    @(negedge clk);
    chk("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    if (txq.size() != 0) void'(txq.pop_front());
    chk("tx_valid_after", 32'(tx_valid), 32'(txq.size() != 0));
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n;

    // Reset state
    #12;
    chk("reset_outputs", {uart_arready, uart_awready, uart_wready, uart_rvalid, uart_bvalid,
                          tx_valid, uart_rresp, uart_bresp}, 0);
    chk("reset_rdata", uart_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("ready_before_clk", {uart_arready, uart_awready, uart_wready}, 3'b000);
    @(negedge clk);
    chk("ready_after_clk", {uart_arready, uart_awready, uart_wready}, 3'b111);

    // Single RX byte then underflow
    m_rx(8'h41);
    m_read(2'd0);
    m_read(2'd0);

    // Single TX byte with the transmitter stalled
    m_write(2'd1, 32'h0000_005A, 4'b0001);
    m_tx_pop();

    // Fill TX, overflow, drain in order
    for (int i = 0; i < 17; i++) m_write(2'd1, 32'(8'h10 + i), 4'b0001);
    m_read(2'd2);
    chk("stat_tx_full", stat_exp(), 32'h08);
    for (int i = 0; i < 16; i++) m_tx_pop();

    // RX overrun with one TX byte pending
    m_write(2'd1, 32'h0000_00C3, 4'b1111);
    for (int i = 0; i < 17; i++) m_rx(8'(i));
    chk("stat_overrun_model", stat_exp(), 32'h23);
    m_read(2'd2);
    m_read(2'd2);
    for (int i = 0; i < 16; i++) m_read(2'd0);
    m_tx_pop();

    // W leads AW by 3 cycles; response held off by bready
    @(negedge clk);
    uart_wdata = 32'h0000_0077; uart_wstrb = 4'b0001; uart_wvalid = 1'b1;
    @(negedge clk);
    uart_wvalid = 1'b0;
    chk("wready_held", {uart_wready, uart_awready}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    uart_awaddr = rand_addr(2'd1); uart_awvalid = 1'b1;
    @(negedge clk);
    uart_awvalid = 1'b0;
    n = 0;
    while (!uart_bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid_seen", 32'(uart_bvalid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {uart_bvalid, uart_awready, uart_wready, uart_bresp}, 5'b10000);
    end
    uart_bready = 1'b1;
    @(negedge clk);
    uart_bready = 1'b0;
    chk("b_release", {uart_bvalid, uart_awready, uart_wready}, 3'b011);
    txq.push_back(8'h77);
    m_tx_pop();

    // Flush both FIFOs
    m_rx(8'hA1); m_rx(8'hA2);
    m_write(2'd1, 32'h0000_00B1, 4'b0001);
    m_write(2'd1, 32'h0000_00B2, 4'b0001);
    m_write(2'd3, 32'h0000_0003, 4'b0001);
    m_read(2'd2);
    chk("stat_after_flush", stat_exp(), 32'h04);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: m_rx(8'($urandom()));
        3, 4:    m_read(2'd0);
        5:       m_read(2'($urandom()));
        6:       m_write(2'd1, $urandom(), ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom()) | 4'b0001);
        7:       m_tx_pop();
        8:       m_write(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2, $urandom(), 4'($urandom()));
        default: if ($urandom_range(0, 3) == 0) m_write(2'd3, 32'($urandom_range(0, 3)), 4'b0001);
                 else m_read(2'd2);
      endcase
    end

    // Reset while a read response is pending
    m_rx(8'h5C);
    @(negedge clk);
    uart_araddr = rand_addr(2'd0); uart_arvalid = 1'b1; uart_rready = 1'b0;
    @(negedge clk);
    uart_arvalid = 1'b0;
    chk("rvalid_pending", 32'(uart_rvalid), 32'd1);
    #2 rstn = 1'b0;
    #1 chk("async_reset", {uart_rvalid, uart_arready, uart_rdata}, 0);
    @(negedge clk);
    rstn = 1'b1;
    rxq.delete(); txq.delete(); ovr = 1'b0;
    @(negedge clk);
    m_read(2'd2);
    m_read(2'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
